// File: rtl/rf_safe_shutdown_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_safe_shutdown_if
// Description : Control/amplitude bundle between a controller (master) and
//               the RF safe-shutdown block (slave).
//               master drives : wd_warning, wd_triggered, clear, amp_in
//               slave drives  : amp_out, rf_enable, fault_latched, state,
//                               shutdown_count
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_safe_shutdown_if #(
    parameter int WIDTH = 16
) ();
    logic             wd_warning;      // watchdog pre-expiry warning level
    logic             wd_triggered;    // watchdog expired level
    logic             clear;           // software acknowledge pulse
    logic [WIDTH-1:0] amp_in;          // requested carrier amplitude
    logic [WIDTH-1:0] amp_out;         // registered amplitude to modulator
    logic             rf_enable;       // registered RF output enable
    logic             fault_latched;   // sticky shutdown indication
    logic [2:0]       state;           // current FSM encoding
    logic [7:0]       shutdown_count;  // saturating count of RAMP entries

    modport master (
        output wd_warning, wd_triggered, clear, amp_in,
        input  amp_out, rf_enable, fault_latched, state, shutdown_count
    );

    modport slave (
        input  wd_warning, wd_triggered, clear, amp_in,
        output amp_out, rf_enable, fault_latched, state, shutdown_count
    );
endinterface
`default_nettype wire

// File: rtl/rf_safe_shutdown.sv
`default_nettype none
// ============================================================================
// Module      : rf_safe_shutdown
// Description : Watchdog-driven RF output shutdown. Passes (or attenuates)
//               the requested amplitude, ramps it down to zero on watchdog
//               expiry, stays muted until acknowledged, dwells for a fixed
//               hold time, then ramps back up to the requested amplitude.
// Ports       : clk  - single clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - rf_safe_shutdown_if slave modport (watchdog levels,
//                      clear pulse, amplitude in/out, status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_safe_shutdown #(
    parameter int WIDTH       = 16,
    parameter int RAMP_STEP   = 256,
    parameter int WARN_SHIFT  = 1,
    parameter int HOLD_CYCLES = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rf_safe_shutdown_if.slave bus
);

    typedef enum logic [2:0] {
        ST_NORMAL  = 3'd0,
        ST_WARN    = 3'd1,
        ST_RAMP    = 3'd2,
        ST_MUTED   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam int                  c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
    // Two guard bits so the up-ramp sum can exceed the word without wrapping.
    localparam logic [WIDTH+1:0]    c_step      = (WIDTH+2)'(RAMP_STEP);

    state_t              r_state;
    logic [WIDTH-1:0]    r_amp;
    logic                r_rf;
    logic                r_fault;
    logic [7:0]          r_count;
    logic [c_hold_w-1:0] r_hold_cnt;

    logic [WIDTH+1:0]    w_amp_ext;
    logic [WIDTH+1:0]    w_in_ext;
    logic [WIDTH+1:0]    w_amp_up;
    logic [WIDTH-1:0]    w_amp_dec;
    logic [WIDTH-1:0]    w_amp_inc;
    logic [WIDTH-1:0]    w_amp_warn;
    logic                w_enter_ramp;

    assign w_amp_ext  = {2'b00, r_amp};
    assign w_in_ext   = {2'b00, bus.amp_in};
    assign w_amp_up   = w_amp_ext + c_step;
    // Down-ramp floors at zero instead of wrapping.
    assign w_amp_dec  = (w_amp_ext <= c_step) ? '0 : (r_amp - c_step[WIDTH-1:0]);
    // Up-ramp clamps to the live amp_in, so a lowered target takes effect at once.
    assign w_amp_inc  = (w_amp_up >= w_in_ext) ? bus.amp_in : w_amp_up[WIDTH-1:0];
    assign w_amp_warn = bus.amp_in >> WARN_SHIFT;

    // Watchdog expiry preempts everything in the states it may interrupt;
    // RAMP and MUTED ignore it. Unused encodings fall into RAMP as a fault.
    always_comb begin
        w_enter_ramp = 1'b0;
        case (r_state)
            ST_NORMAL, ST_WARN, ST_HOLD, ST_RECOVER: w_enter_ramp = bus.wd_triggered;
            ST_RAMP, ST_MUTED:                       w_enter_ramp = 1'b0;
            default:                                 w_enter_ramp = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_NORMAL;
            r_amp      <= '0;
            r_rf       <= 1'b0;
            r_fault    <= 1'b0;
            r_count    <= 8'd0;
            r_hold_cnt <= '0;
        end else if (w_enter_ramp) begin
            // amp_out is held so the ramp starts from the current level.
            r_state    <= ST_RAMP;
            r_rf       <= 1'b1;
            r_fault    <= 1'b1;
            r_hold_cnt <= '0;
            if (r_count != 8'hFF) begin
                r_count <= r_count + 8'd1;
            end
        end else begin
            case (r_state)
                ST_NORMAL, ST_WARN: begin
                    r_rf <= 1'b1;
                    if (bus.wd_warning) begin
                        r_state <= ST_WARN;
                        r_amp   <= w_amp_warn;
                    end else begin
                        r_state <= ST_NORMAL;
                        r_amp   <= bus.amp_in;
                    end
                end
                ST_RAMP: begin
                    r_rf <= 1'b1;
                    if (r_amp == '0) begin
                        r_state <= ST_MUTED;
                        r_rf    <= 1'b0;
                    end else begin
                        r_amp <= w_amp_dec;
                    end
                end
                ST_MUTED: begin
                    r_amp <= '0;
                    r_rf  <= 1'b0;
                    if (bus.clear && !bus.wd_triggered) begin
                        r_state    <= ST_HOLD;
                        r_fault    <= 1'b0;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    r_amp <= '0;
                    r_rf  <= 1'b0;
                    if (r_hold_cnt == c_hold_last) begin
                        r_state    <= ST_RECOVER;
                        r_rf       <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_hold_one;
                    end
                end
                ST_RECOVER: begin
                    r_rf <= 1'b1;
                    if (r_amp >= bus.amp_in) begin
                        r_state <= ST_NORMAL;
                        r_amp   <= bus.amp_in;
                    end else begin
                        r_amp <= w_amp_inc;
                    end
                end
                default: begin
                    r_state <= ST_RAMP;
                end
            endcase
        end
    end

    assign bus.amp_out        = r_amp;
    assign bus.rf_enable      = r_rf;
    assign bus.fault_latched  = r_fault;
    assign bus.state          = r_state;
    assign bus.shutdown_count = r_count;

endmodule
`default_nettype wire

// File: doc/rf_safe_shutdown.md
RF_SAFE_SHUTDOWN -- requirements
Module: rf_safe_shutdown

Interface
REQ-001 Parameter WIDTH, default 16: amplitude word width.
REQ-002 Parameter RAMP_STEP, default 256: amplitude change per cycle in RAMP and RECOVER.
REQ-003 Parameter WARN_SHIFT, default 1: right-shift attenuation applied in WARN.
REQ-004 Parameter HOLD_CYCLES, default 1024: muted dwell length after clear.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset; asynchronous and active-high.
REQ-007 Port wd_warning, input, 1: watchdog pre-expiry warning level.
REQ-008 Port wd_triggered, input, 1: watchdog expired level.
REQ-009 Port clear, input, 1: software acknowledge pulse.
REQ-010 Port amp_in, input, WIDTH: requested carrier amplitude, unsigned.
REQ-011 Port amp_out, output, WIDTH: registered amplitude to the modulator.
REQ-012 Port rf_enable, output, 1: registered RF output enable.
REQ-013 Port fault_latched, output, 1: sticky shutdown indication.
REQ-014 Port state, output, 3: current FSM encoding.
REQ-015 Port shutdown_count, output, 8: number of RAMP entries, saturating.

Function
REQ-016 FSM SHALL have states NORMAL=0, WARN=1, RAMP=2, MUTED=3, HOLD=4, RECOVER=5; codes 6-7 SHALL transition to RAMP next cycle.
REQ-017 NORMAL: amp_out <= amp_in each cycle (1-cycle latency), rf_enable=1.
REQ-018 WARN: amp_out <= amp_in >> WARN_SHIFT each cycle, rf_enable=1.
REQ-019 From NORMAL/WARN/HOLD/RECOVER, wd_triggered=1 SHALL enter RAMP next cycle, taking priority over every other condition.
REQ-020 NORMAL -> WARN when wd_warning=1 and wd_triggered=0; WARN -> NORMAL when wd_warning=0 and wd_triggered=0.
REQ-021 RAMP: amp_out decrements by RAMP_STEP per cycle from its value at entry, saturating at 0 (no wrap); rf_enable stays 1.
REQ-022 RAMP -> MUTED on the cycle after amp_out reaches 0; clear and wd_triggered SHALL be ignored in RAMP.
REQ-023 MUTED: amp_out=0, rf_enable=0; exit to HOLD only when clear=1 and wd_triggered=0 in the same cycle.
REQ-024 HOLD: amp_out=0, rf_enable=0, internal counter counts exactly HOLD_CYCLES cycles, then RECOVER.
REQ-025 RECOVER: rf_enable=1; amp_out increments by RAMP_STEP per cycle, saturating at amp_in (no overshoot, no wrap); enter NORMAL on the cycle after amp_out >= amp_in.
REQ-026 amp_in changing during RECOVER SHALL retarget the saturation bound immediately.
REQ-027 fault_latched SHALL set on RAMP entry and clear only on a clear pulse accepted in MUTED.
REQ-028 shutdown_count SHALL increment by 1 on each RAMP entry and hold at 255.
REQ-029 Entering RAMP with amp_out already 0 SHALL reach MUTED after one RAMP cycle.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force state=NORMAL, amp_out=0, rf_enable=0, fault_latched=0, shutdown_count=0, hold counter=0.
REQ-031 First rising edge with rst=0 SHALL load amp_out from amp_in and set rf_enable=1.
REQ-032 rst asserted mid-RAMP/HOLD SHALL abandon the sequence with no residual state.

Verification
REQ-033 amp_in=0x1000, flags low, 3 cycles -> amp_out=0x1000, state=0, rf_enable=1.
REQ-034 wd_warning=1 with amp_in=0x1000 -> next cycle state=1, amp_out=0x0800; deassert -> amp_out=0x1000.
REQ-035 wd_triggered pulse at amp_out=0x1000 -> 16 RAMP cycles to 0, then MUTED, rf_enable=0, fault_latched=1, shutdown_count=1.
REQ-036 In MUTED, clear with wd_triggered=1 -> stays MUTED; clear with wd_triggered=0 -> HOLD for 1024 cycles, then RECOVER reaches 0x1000 in 16 cycles, fault_latched=0.
REQ-037 wd_triggered during RECOVER at amp_out=0x0600 -> RAMP from 0x0600, shutdown_count=2.
REQ-038 rst pulse mid-RAMP (amp_out=0x0800) -> same-cycle amp_out=0, state=0, shutdown_count=0.
